// File: rtl/spi_reg_ctrl_pkg.sv
// spi_reg_pkg: FSM state codes and fixed bytes shared by the SPI register controller
package spi_reg_pkg;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] WR      = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_CAP  = 3'd4;
  localparam logic [2:0] RD_DATA = 3'd5;
  localparam logic [2:0] DISCARD = 3'd6;
  localparam int CMD_RD_BIT = 7;
  localparam logic [7:0] DISCARD_BYTE = 8'hFF;
  localparam logic [7:0] STATUS_BYTE = 8'hA5;
endpackage

// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: shifter byte handshake plus register-file bus around the SPI command sequencer
interface spi_reg_ctrl_if #(parameter int ADDR_W = 4);
  logic frame_active;
  logic rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic tx_load;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic reg_we;
  logic reg_re;
  logic [7:0] reg_rdata;
  logic busy;
  logic [3:0] err_cnt;
  modport master (
    input  frame_active, rx_valid, rx_byte, reg_rdata,
    output tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re, busy, err_cnt
  );
  modport slave (
    output frame_active, rx_valid, rx_byte, reg_rdata,
    input  tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re, busy, err_cnt
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI command/register sequencer; define SPI_REG_CTRL_AUTOINC_EN for address auto-increment
module spi_reg_ctrl #(
  parameter int ADDR_W = 4,
  parameter logic [7:0] STATUS_BYTE = spi_reg_pkg::STATUS_BYTE
) (
  input logic clk,
  input logic rst,
  spi_reg_ctrl_if.master bus
);
  import spi_reg_pkg::*;
  logic [2:0] state_q, state_d;
  logic [7:0] tx_byte_q, tx_byte_d, wdata_q, wdata_d;
  logic tx_load_q, tx_load_d, we_q, we_d, re_q, re_d, busy_q;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nx;
  logic [3:0] err_q, err_d;
  logic legal;
  assign legal = (bus.rx_byte[6:0] >> ADDR_W) == 7'd0;
`ifdef SPI_REG_CTRL_AUTOINC_EN
  assign addr_nx = addr_q + 1'b1;
`else
  assign addr_nx = addr_q;
`endif
  always_comb begin
    state_d = state_q;
    tx_byte_d = tx_byte_q;
    tx_load_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = 1'b0;
    re_d = 1'b0;
    err_d = err_q;
    if (state_q != IDLE && !bus.frame_active) state_d = IDLE;
    else case (state_q)
      IDLE: if (bus.frame_active) begin
        state_d = CMD;
        tx_byte_d = STATUS_BYTE;
        tx_load_d = 1'b1;
      end
      CMD: if (bus.rx_valid) begin
        if (!legal) begin
          state_d = DISCARD;
          tx_byte_d = DISCARD_BYTE;
          tx_load_d = 1'b1;
          err_d = err_q + {3'd0, err_q != 4'hF};
        end else begin
          addr_d = bus.rx_byte[ADDR_W-1:0];
          state_d = bus.rx_byte[CMD_RD_BIT] ? RD_REQ : WR;
          re_d = bus.rx_byte[CMD_RD_BIT];
        end
      end
      WR: begin
        if (we_q) addr_d = addr_nx;
        if (bus.rx_valid) begin
          we_d = 1'b1;
          wdata_d = bus.rx_byte;
        end
      end
      RD_REQ: state_d = RD_CAP;
      RD_CAP: begin
        state_d = RD_DATA;
        tx_byte_d = bus.reg_rdata;
        tx_load_d = 1'b1;
      end
      // the strobe is issued together with the new address so both land in RD_REQ
      RD_DATA: if (bus.rx_valid) begin
        state_d = RD_REQ;
        addr_d = addr_nx;
        re_d = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_byte_q <= '0;
      tx_load_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      err_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_byte_q <= tx_byte_d;
      tx_load_q <= tx_load_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      re_q <= re_d;
      err_q <= err_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign bus.tx_byte = tx_byte_q;
  assign bus.tx_load = tx_load_q;
  assign bus.reg_addr = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we = we_q;
  assign bus.reg_re = re_q;
  assign bus.busy = busy_q;
  assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed frames with write/tx scoreboards against a bench-side register model
module tb_spi_reg_ctrl;
`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam logic [3:0] INC = 4'd1;
`else
  localparam logic [3:0] INC = 4'd0;
`endif
  logic clk = 1'b0;
  logic rst;
  int vec = 0;
  int miss = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  logic [11:0] wq[$];
  logic [7:0] tq[$];
  logic [7:0] mem [16];
  logic [7:0] model [16];
  spi_reg_ctrl_if #(.ADDR_W(4)) bus();
  spi_reg_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] init_val(input int i);
    return i == 15 ? 8'h5A : i == 0 ? 8'hC3 : 8'(i * 3);
  endfunction
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    else begin
      if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.reg_we | bus.reg_re) chk("we_re_excl", bus.reg_we & bus.reg_re, 0);
    if (bus.reg_re) re_cnt++;
    if (bus.reg_we) begin
      we_cnt++;
      chk("we_expected", wq.size() != 0, 1);
      if (wq.size() != 0) chk("write", {bus.reg_addr, bus.reg_wdata}, wq.pop_front());
    end
    if (bus.tx_load) begin
      chk("tx_expected", tq.size() != 0, 1);
      if (tq.size() != 0) chk("tx_byte", bus.tx_byte, tq.pop_front());
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    bus.rx_byte = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    tick(3);
  endtask
  task automatic wr_data(input logic [3:0] a, input logic [7:0] d);
    wq.push_back({a, d});
    model[a] = d;
    send(d);
  endtask
  task automatic rd_step(input logic [7:0] b, input logic [7:0] exp);
    tq.push_back(exp);
    bus.rx_byte = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    chk("rd_re", bus.reg_re, 1);
    tick(1);
    chk("rd_early", bus.tx_load, 0);
    tick(1);
    chk("rd_load", bus.tx_load, 1);
    chk("rd_data", bus.tx_byte, exp);
    tick(1);
  endtask
  task automatic start_frame;
    tq.push_back(8'hA5);
    bus.frame_active = 1'b1;
    tick(1);
    chk("busy_on", bus.busy, 1);
    tick(1);
  endtask
  task automatic end_frame;
    bus.frame_active = 1'b0;
    tick(2);
    chk("busy_off", bus.busy, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int we0, re0;
    rst = 1'b1;
    bus.frame_active = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte = 8'h00;
    for (int i = 0; i < 16; i++) model[i] = init_val(i);
    tick(3);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_tx_load", bus.tx_load, 0);
    chk("rst_addr", bus.reg_addr, 0);
    chk("rst_wdata", bus.reg_wdata, 0);
    chk("rst_we", bus.reg_we, 0);
    chk("rst_re", bus.reg_re, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_cnt, 0);
    rst = 1'b0;
    tick(2);
    start_frame();
    send(8'h03);
    wr_data(4'h3, 8'h11);
    wr_data(4'h3 + INC, 8'h22);
    end_frame();
    start_frame();
    re0 = re_cnt;
    rd_step(8'h8F, model[15]);
    rd_step(8'h00, model[4'hF + INC]);
    end_frame();
    chk("rd_re_count", re_cnt - re0, 2);
    start_frame();
    send(8'h02);
    wr_data(4'h2, 8'h05);
    end_frame();
    start_frame();
    rd_step(8'h82, 8'h05);
    end_frame();
    start_frame();
    send(8'h06);
    wr_data(4'h6, 8'h77);
    we0 = we_cnt;
    bus.frame_active = 1'b0;
    bus.rx_byte = 8'h88;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_we", bus.reg_we, 0);
    tick(4);
    chk("abort_no_write", we_cnt - we0, 0);
    we0 = we_cnt;
    re0 = re_cnt;
    for (int f = 1; f <= 20; f++) begin
      start_frame();
      tq.push_back(8'hFF);
      send(8'h20);
      send(8'h01);
      send(8'h02);
      send(8'h03);
      end_frame();
      if (f == 1 || f == 15 || f == 20) chk("err_cnt", bus.err_cnt, f > 15 ? 15 : f);
    end
    chk("discard_no_we", we_cnt - we0, 0);
    chk("discard_no_re", re_cnt - re0, 0);
    start_frame();
    bus.rx_byte = 8'h84;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    chk("midread_re", bus.reg_re, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_byte", bus.tx_byte, 0);
    chk("arst_re", bus.reg_re, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_err", bus.err_cnt, 0);
    chk("arst_addr", bus.reg_addr, 0);
    bus.frame_active = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    tq.push_back(8'hA5);
    bus.frame_active = 1'b1;
    tick(1);
    chk("restart_load", bus.tx_load, 1);
    chk("restart_byte", bus.tx_byte, 8'hA5);
    end_frame();
    chk("wq_drained", wq.size(), 0);
    chk("tq_drained", tq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
